// File: rtl/muldiv_pkg.sv
// Shared op encodings and controller states for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              div_i,
    output logic [2*WIDTH:0]  acc_o
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum  = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
        shl  = {acc_i[2*WIDTH-1:0], 1'b0};
        diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd_i};
        acc_o = shl;
        if (div_i) begin
            // A clear borrow bit means the trial subtraction fits: keep it and set the quotient bit.
            if (!diff[WIDTH+1]) begin
                acc_o = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
            end
        end else if (acc_i[0]) begin
            acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and a start/busy/done handshake.
// state | meaning:  IDLE accepts start | RUN one bit per edge | FIX sign correction and HI/LO write
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d, step_acc;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_muldiv, op_signed, op_div;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign prod_fix  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (is_div_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && op_muldiv) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = 1'b0;
                    // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                    acc_d     = {{(WIDTH+1){1'b0}}, op_div ? a_mag : b_mag};
                    opnd_d    = op_div ? b_mag : a_mag;
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = a;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = a;
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Zero divisor leaves |a| as the remainder, so the sign fix restores hi = a.
                    hi_d  = rem_fix;
                    lo_d  = (opnd_q == '0) ? '1 : quo_fix;
                    dbz_d = (opnd_q == '0);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle combinational multiplier plus HI/LO pair in the MIPS datapath.
- Adds signed/unsigned multiply, signed/unsigned divide, MTHI/MTLO, parametrised width, and a start/busy/done handshake for multi-cycle stall control.
- Sits beside the ALU; operands come from regfile rd1 (rs) and rd2 (rt). MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation, encoded in muldiv_pkg.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  operation in flight; controller stalls MF*/MULT/DIV while high.
- done  out  1  one-cycle pulse: HI/LO updated by MULT/DIV.
- div_by_zero  out  1  sticky flag for last DIV/DIVU; cleared by next accepted MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; hi=lo=0; busy=0; done=0; div_by_zero=0.
  - Overrides everything, including an operation mid-run. No done pulse is issued for the aborted operation.
- Op codes: MULT, MULTU, DIV, DIVU, MTHI, MTLO. Remaining codes are NOP: accepted, no state change.
- States and transitions:
  - IDLE -> RUN on start with MULT/DIV/DIVU/MULTU.
  - RUN -> FIX when the counter reaches WIDTH-1.
  - FIX -> IDLE.
- Accept edge E0 (start=1, busy=0, MUL/DIV op):
  - Latch sign flags.
  - Latch magnitudes |a|, |b| for signed ops; raw values for unsigned ops.
  - Counter=0; busy=1 from the next cycle.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing the quotient, with the remainder in the high half.
- FIX, edge E_(WIDTH+1):
  - Apply sign correction and write HI/LO.
  - busy falls after this edge; done=1 for exactly the following cycle.
  - Total latency: WIDTH+1 edges from the accept edge to HI/LO update.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
- Divide result:
  - lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - b==0: hi=a, lo=all ones, div_by_zero=1. Still takes the full latency.
  - Signed MIN / -1: lo=MIN, hi=0, no flag.
- MTHI/MTLO:
  - Accepted only when busy=0.
  - Writes hi (or lo) = a at the accept edge.
  - busy stays 0; no done pulse.
- start while busy=1: ignored entirely. Operands and op of the running operation are unaffected.
- start on the same cycle done=1: legal, accepted (busy=0 then).
- hi/lo hold their old values during RUN; they change only at FIX, MTHI/MTLO, or reset.

Decomposition:
- muldiv_pkg holds:
  - op encodings (MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5);
  - the state enum (IDLE, RUN, FIX).
- Sub-module muldiv_step: combinational single-iteration datapath, parametrised by WIDTH. Inputs: accumulator and mode; outputs: next accumulator (add-shift or sub-shift-restore).
- Top-level muldiv_unit owns the FSM, counter, sign fixup, and HI/LO registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles, done pulse, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; then DIVU a=7 b=2 -> lo=3 hi=1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, div_by_zero=0.
- DIV a=5 b=0 -> full latency, hi=5 lo=0xFFFFFFFF div_by_zero=1; next MULTU 2*3 clears the flag, lo=6 hi=0.
- MULTU 3*4 started; start+MTHI a=0x1234 pulsed at cycle 5 -> ignored, hi=0 lo=12. rst=0 at cycle 10 of a new DIVU -> next cycle busy=0 hi=lo=0, no done ever.
- MTHI a=0xDEADBEEF then MTLO a=0xCAFEF00D in consecutive cycles -> hi/lo updated one edge each, busy=0, done=0 throughout.
